// File: rtl/uart_pkg.sv
// Shared encodings and frame constants for the operand UART link.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 receiver: synchronizes the RX line and strobes o_byte_valid for one
// cycle when a byte with a good stop bit has been assembled in o_rx_data.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_din,
  output logic                 o_byte_valid,
  output logic [DATA_BITS-1:0] o_rx_data
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic                 r_din_s1;
  logic                 r_din_s2;
  uart_state_e          r_state;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bit;
  logic                 r_valid;
  logic [DATA_BITS-1:0] r_shift;
  logic                 w_bit_tick;

  assign w_bit_tick = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_din_s1 <= 1'b1;
      r_din_s2 <= 1'b1;
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_din_s1 <= i_din;
      r_din_s2 <= r_din_s1;
      r_valid  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          r_bit <= '0;
          if (!r_din_s2) r_state <= ST_START;
        end
        // Re-check at mid start bit so short low pulses are rejected.
        ST_START: begin
          if (r_cnt == CNT_HALF) begin
            r_cnt   <= '0;
            r_state <= r_din_s2 ? ST_IDLE : ST_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_bit_tick) begin
            r_cnt <= '0;
            if (r_bit == BIT_LAST) r_state <= ST_STOP;
            else                   r_bit   <= r_bit + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_bit_tick) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            r_valid <= r_din_s2;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_DATA && w_bit_tick)
      r_shift <= {r_din_s2, r_shift[DATA_BITS-1:1]};
  end

  assign o_byte_valid = r_valid;
  assign o_rx_data    = r_shift;

endmodule

// File: rtl/uart_operand_link.sv
// Operand link: pairs received bytes into a/b with a ready flag, and sends
// the result byte as one 8N1 frame on each accepted tx_en rising edge.
module uart_operand_link
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       din,
  output logic       dout,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic       ready,
  input  logic [7:0] result,
  input  logic       tx_en,
  output logic       tx_busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic                 w_byte_valid;
  logic [DATA_BITS-1:0] w_rx_data;

  logic [7:0]           r_a;
  logic [7:0]           r_b;
  logic                 r_ready;
  logic                 r_byte_sel;

  logic                 r_tx_en_d;
  uart_state_e          r_tx_state;
  logic [CW-1:0]        r_tx_cnt;
  logic [BW-1:0]        r_tx_bit;
  logic                 r_dout;
  logic                 r_tx_busy;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 w_tx_start;
  logic                 w_tx_tick;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_din        (din),
    .o_byte_valid (w_byte_valid),
    .o_rx_data    (w_rx_data)
  );

  // Operand sequencing: framing errors never reach here, so byte_sel holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_ready    <= 1'b0;
      r_byte_sel <= 1'b0;
    end else if (w_byte_valid) begin
      if (!r_byte_sel) begin
        r_a        <= w_rx_data;
        r_ready    <= 1'b0;
        r_byte_sel <= 1'b1;
      end else begin
        r_b        <= w_rx_data;
        r_ready    <= 1'b1;
        r_byte_sel <= 1'b0;
      end
    end
  end

  // Edges arriving while a frame is in flight are dropped, not queued.
  assign w_tx_start = tx_en && !r_tx_en_d && (r_tx_state == ST_IDLE);
  assign w_tx_tick  = (r_tx_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_en_d  <= 1'b0;
      r_tx_state <= ST_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_dout     <= 1'b1;
      r_tx_busy  <= 1'b0;
    end else begin
      r_tx_en_d <= tx_en;
      case (r_tx_state)
        ST_IDLE: begin
          r_tx_cnt <= '0;
          r_tx_bit <= '0;
          if (w_tx_start) begin
            r_tx_state <= ST_START;
            r_dout     <= 1'b0;
            r_tx_busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (w_tx_tick) begin
            r_tx_cnt   <= '0;
            r_tx_state <= ST_DATA;
            r_dout     <= r_tx_shift[0];
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_tx_tick) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == BIT_LAST) begin
              r_tx_state <= ST_STOP;
              r_dout     <= 1'b1;
            end else begin
              r_tx_bit <= r_tx_bit + 1'b1;
              r_dout   <= r_tx_shift[1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_tx_tick) begin
            r_tx_cnt   <= '0;
            r_tx_state <= ST_IDLE;
            r_tx_busy  <= 1'b0;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        default: r_tx_state <= ST_IDLE;
      endcase
    end
  end

  // The shift register moves in lockstep with r_dout picking up bit [1].
  always_ff @(posedge clk) begin
    if (w_tx_start)
      r_tx_shift <= result;
    else if (r_tx_state == ST_DATA && w_tx_tick)
      r_tx_shift <= {1'b0, r_tx_shift[DATA_BITS-1:1]};
  end

  assign a       = r_a;
  assign b       = r_b;
  assign ready   = r_ready;
  assign dout    = r_dout;
  assign tx_busy = r_tx_busy;

endmodule

// File: doc/uart_operand_link.md
# uart_operand_link

Serial link engine between the board's RS-232 pins and the memory-mapped peripheral block. It receives two 8-bit operands over an 8N1 UART line and presents them as `a`, `b` with a `ready` flag. On a CPU-driven `tx_en` rising edge it transmits the 8-bit `result` back over the same link. It is instantiated inside the peripheral block, which maps `a`, `b`, `ready`, `result` and `tx_en` onto its register window.

## Interface
- `CLKS_PER_BIT`, default 5208: clock cycles per bit period (9600 baud at 50 MHz); must be at least 4.
- `clk`  in  1  system clock, all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- `din`  in  1  serial RX line, idle high, asynchronous to `clk`
- `dout`  out  1  serial TX line, idle high
- `a`  out  8  first received operand
- `b`  out  8  second received operand
- `ready`  out  1  operand pair complete
- `result`  in  8  byte to transmit, sampled at the `tx_en` rising edge
- `tx_en`  in  1  transmit request, rising-edge triggered
- `tx_busy`  out  1  TX frame in progress

## Operation
- **Reset values:** `dout`=1, `a`=0, `b`=0, `ready`=0, `tx_busy`=0. Both FSMs go to IDLE and `byte_sel`=0.
- **RX input:** `din` passes through a 2-flop synchronizer. All RX logic uses the synchronized value.
- **RX FSM states:** IDLE, START, DATA, STOP.
  - IDLE→START on a synchronized low level.
  - START: wait CLKS_PER_BIT/2 cycles, then re-sample. If the line is high, treat it as a glitch and return to IDLE. If low, go to DATA.
  - DATA: sample 8 bits LSB first, each CLKS_PER_BIT cycles after the previous sample.
  - STOP: sample CLKS_PER_BIT after the last data bit. If the line is 1, the byte is valid. If 0, it is a framing error: discard the byte and leave `byte_sel` unchanged. Go to IDLE either way.
- **Byte sequencing for a valid byte:**
  - If `byte_sel`=0: load `a`, clear `ready`, set `byte_sel`=1.
  - If `byte_sel`=1: load `b`, set `ready`, set `byte_sel`=0.
  - `ready` stays high until the next valid first byte completes.
- **TX trigger:** the TX block registers `tx_en` into `tx_en_d`. A rising edge is `tx_en & ~tx_en_d`.
  - If the TX FSM is in IDLE on a rising edge: latch `result` into the shift register and go to START.
  - If TX is busy, the edge is ignored and not queued.
- **TX FSM states:** IDLE, START, DATA, STOP.
  - START: `dout`=0.
  - DATA: 8 bits, LSB first.
  - STOP: `dout`=1.
  - Each state or bit lasts exactly CLKS_PER_BIT cycles.
- `tx_busy` is high in every TX state except IDLE.
- RX and TX are fully independent. Full-duplex operation is required.
- The RX bit counter wraps at CLKS_PER_BIT-1 and uses $clog2(CLKS_PER_BIT) bits. The TX counter is the same.

## Timing
- **`din` to RX FSM:** 2 cycles of latency.
- **RX output update:** `a`/`b`/`ready` update on the clock edge after the stop-bit sample. The stop-bit sample falls about 9.5·CLKS_PER_BIT + 3 cycles after the falling edge of `din`.
- **TX start:** `dout` falls and `tx_busy` rises on the edge after the cycle in which the `tx_en` rising edge is detected (1 cycle of latency).
- **TX frame length:** 10·CLKS_PER_BIT cycles. `tx_busy` falls on the same edge that TX returns to IDLE. A new `tx_en` edge in that same cycle or later is accepted.
- **`result` sampling:** `result` is sampled only at the trigger cycle. Later changes do not affect the frame in flight.
- **Reset mid-frame:** asserting `reset_n`=0 at any time forces all outputs to their reset values immediately (asynchronously). Partial frames are discarded and nothing resumes after reset.
- **Simultaneous events:** if a valid RX byte completes in the same cycle as a TX trigger, both are handled. There is no arbitration.

## Structure
- **Shared package `uart_pkg`:**
  - RX and TX state encodings: 2-bit IDLE=0, START=1, DATA=2, STOP=3.
  - `DATA_BITS`=8.
  - `FRAME_BITS`=10.
- **Sub-module `uart_rx_byte`:** synchronizer, RX FSM, and a `byte_valid` strobe with `rx_data` output.
- **Top level:** instantiates `uart_rx_byte` and contains the operand sequencing, `ready`, and the TX FSM.

## Test plan
Use CLKS_PER_BIT=16 for all scenarios.
1. **Reset:** hold `reset_n`=0 → `dout`=1, `a`=`b`=0, `ready`=0, `tx_busy`=0. Release, then idle for 100 cycles → no change.
2. **Operand pair:** send 0x35, then 0x0A → after byte 1, `a`=0x35 and `ready`=0. After byte 2, `b`=0x0A and `ready`=1. A third byte 0x11 → `a`=0x11, `ready`=0.
3. **Transmit:** `result`=0xA5, pulse `tx_en` → `dout` carries 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles wide. `tx_busy` is high for exactly 160 cycles.
4. **Framing error:** send 0x7E with the stop bit driven to 0 → `a` is unchanged. The next valid byte 0x22 loads `a`.
5. **Glitch and busy:** a 5-cycle low pulse on `din` → no byte. A second `tx_en` edge 50 cycles into a frame → only one frame is sent and the second `result` is ignored.
6. **Reset mid-operation:** assert reset at cycle 70 of a TX frame and mid-way through an RX byte → `dout`=1 immediately and `ready`=0. A subsequent clean pair 0x01, 0x02 is received correctly.
